// File: rtl/qdma_stm_h2c_pkt_arb_pkg.sv
// qdma_stm_h2c_pkt_arb_pkg: shared arbiter state type and source-index width helper
package qdma_stm_h2c_pkt_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} h2c_arb_state_e;
  function automatic int src_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/qdma_stm_h2c_pkt_arb_rr_pick.sv
// qdma_stm_rr_pick: combinational rotate-priority pick of the first set req bit at or after ptr (req/ptr in, gnt_oh/gnt_idx/any out)
module qdma_stm_rr_pick
  import qdma_stm_h2c_pkt_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = src_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_oh,
  output logic [W-1:0] gnt_idx,
  output logic         any
);
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) gnt_idx = W'((int'(ptr) + i) % N);
    any = |req;
    gnt_oh = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/qdma_stm_h2c_pkt_arb.sv
// qdma_stm_h2c_pkt_arb: packet-atomic round-robin arbiter of NUM_SRC H2C streams (in_*) onto one registered stream (out_*), with per-source packet counters (pkt_cnt), sticky missing-header flag (hdr_err/hdr_err_src) and lock status (busy)
module qdma_stm_h2c_pkt_arb
  import qdma_stm_h2c_pkt_arb_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int MAX_DATA_WIDTH = 512,
  parameter int TDEST_BITS     = 16,
  parameter int CNT_W          = 16,
  localparam int SW            = src_w(NUM_SRC)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0]                  src_en,
  input  logic [NUM_SRC*MAX_DATA_WIDTH-1:0]   in_tdata,
  input  logic [NUM_SRC*TDEST_BITS-1:0]       in_tdest,
  input  logic [NUM_SRC-1:0]                  in_tuser,
  input  logic [NUM_SRC-1:0]                  in_tlast,
  input  logic [NUM_SRC-1:0]                  in_tvalid,
  output logic [NUM_SRC-1:0]                  in_tready,
  output logic [MAX_DATA_WIDTH-1:0]           out_tdata,
  output logic [TDEST_BITS-1:0]               out_tdest,
  output logic                                out_tuser,
  output logic                                out_tlast,
  output logic [SW-1:0]                       out_src_id,
  output logic                                out_tvalid,
  input  logic                                out_tready,
  output logic [NUM_SRC*CNT_W-1:0]            pkt_cnt,
  output logic                                hdr_err,
  output logic [SW-1:0]                       hdr_err_src,
  output logic                                busy
);
  h2c_arb_state_e state, state_nxt;
  logic [SW-1:0] gnt, rr_ptr, pick_idx, sel;
  logic [NUM_SRC-1:0] pick_oh;
  logic [NUM_SRC-1:0][CNT_W-1:0] cnt;
  logic pick_any, slot_free, acc, acc_last;
  assign slot_free = !out_tvalid || out_tready;
  assign busy = state == ARB_LOCKED;
  assign pkt_cnt = cnt;
  qdma_stm_rr_pick #(.N(NUM_SRC), .W(SW)) u_pick (
    .req(in_tvalid & src_en),
    .ptr(rr_ptr),
    .gnt_oh(pick_oh),
    .gnt_idx(pick_idx),
    .any(pick_any)
  );
  always_comb begin
    sel = state == ARB_IDLE ? pick_idx : gnt;
    in_tready = rst || !slot_free ? '0 :
                state == ARB_LOCKED ? NUM_SRC'(1) << gnt :
                pick_any ? pick_oh : '0;
    acc = in_tvalid[sel] && in_tready[sel];
    acc_last = acc && in_tlast[sel];
    state_nxt = !acc ? state : in_tlast[sel] ? ARB_IDLE : ARB_LOCKED;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt <= '0;
      rr_ptr <= '0;
      out_tvalid <= 1'b0;
      out_tdata <= '0;
      out_tdest <= '0;
      out_tuser <= 1'b0;
      out_tlast <= 1'b0;
      out_src_id <= '0;
      cnt <= '0;
      hdr_err <= 1'b0;
      hdr_err_src <= '0;
    end else begin
      state <= state_nxt;
      out_tvalid <= acc || (out_tvalid && !out_tready);
      if (acc) begin
        gnt <= sel;
        out_tdata <= in_tdata[int'(sel)*MAX_DATA_WIDTH +: MAX_DATA_WIDTH];
        out_tdest <= in_tdest[int'(sel)*TDEST_BITS +: TDEST_BITS];
        out_tuser <= in_tuser[sel];
        out_tlast <= in_tlast[sel];
        out_src_id <= sel;
      end
      if (acc_last) begin
        rr_ptr <= SW'((int'(sel) + 1) % NUM_SRC);
        cnt[sel] <= cnt[sel] + 1'b1;
      end
      if (acc && state == ARB_IDLE && !in_tuser[sel] && !hdr_err) begin
        hdr_err <= 1'b1;
        hdr_err_src <= sel;
      end
    end
  end
endmodule

// File: tb/tb_qdma_stm_h2c_pkt_arb.sv
// tb_qdma_stm_h2c_pkt_arb: directed self-checking bench for the packet-atomic H2C arbiter
module tb_qdma_stm_h2c_pkt_arb;
  localparam int NS = 4, DW = 32, TD = 16, CW = 8, SW = 2;
  typedef struct packed {logic [DW-1:0] d; logic u; logic l;} beat_t;
  typedef logic [SW+TD+DW+1:0] obs_t;
  logic clk = 1'b0, rst = 1'b1, out_tready = 1'b1;
  logic [NS-1:0] src_en = '1, in_tuser = '0, in_tlast = '0, in_tvalid = '0, in_tready;
  logic [NS*DW-1:0] in_tdata = '0;
  logic [NS*TD-1:0] in_tdest = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
  logic [DW-1:0] out_tdata;
  logic [TD-1:0] out_tdest;
  logic out_tuser, out_tlast, out_tvalid, hdr_err, busy;
  logic [SW-1:0] out_src_id, hdr_err_src;
  logic [NS*CW-1:0] pkt_cnt;
  logic [NS-1:0] hs;
  beat_t q[NS][$];
  obs_t log_q[$], prev_o;
  int log_cyc[$];
  int vectors = 0, miscompares = 0, cyc = 0, bad_oh = 0, busy_seen = 0, unstable = 0;
  logic prev_stall = 1'b0;
  qdma_stm_h2c_pkt_arb #(.NUM_SRC(NS), .MAX_DATA_WIDTH(DW), .TDEST_BITS(TD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .src_en(src_en), .in_tdata(in_tdata), .in_tdest(in_tdest),
    .in_tuser(in_tuser), .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tdest(out_tdest), .out_tuser(out_tuser), .out_tlast(out_tlast),
    .out_src_id(out_src_id), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .pkt_cnt(pkt_cnt), .hdr_err(hdr_err), .hdr_err_src(hdr_err_src), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] mkd(input int s, input int id, input int b);
    return {8'(s), 8'(id), 8'(b), 8'hA5};
  endfunction
  function automatic obs_t exp_obs(input int s, input int id, input int b, input int n, input bit hdr);
    return {SW'(s), TD'(16'h0100 + s), mkd(s, id, b), 1'(hdr && b == 0), 1'(b == n - 1)};
  endfunction
  function automatic logic [CW-1:0] cnt(input int i);
    return pkt_cnt[i*CW +: CW];
  endfunction
  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      in_tvalid[i] = q[i].size() > 0;
      if (q[i].size() > 0) begin
        in_tdata[i*DW +: DW] = q[i][0].d;
        in_tuser[i] = q[i][0].u;
        in_tlast[i] = q[i][0].l;
      end
    end
  endtask
  task automatic push_pkt(input int s, input int id, input int n, input bit hdr);
    for (int b = 0; b < n; b++) q[s].push_back('{d: mkd(s, id, b), u: hdr && b == 0, l: b == n - 1});
  endtask
  task automatic tick();
    obs_t o;
    @(negedge clk);
    o = {out_src_id, out_tdest, out_tdata, out_tuser, out_tlast};
    hs = in_tvalid & in_tready;
    if (!$onehot0(in_tready)) bad_oh++;
    if (busy) busy_seen++;
    if (prev_stall && o !== prev_o) unstable++;
    prev_stall = out_tvalid && !out_tready;
    prev_o = o;
    if (out_tvalid && out_tready) begin
      log_q.push_back(o);
      log_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (hs[i]) void'(q[i].pop_front());
    drive();
  endtask
  task automatic wait_log(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && log_q.size() < n; k++) tick();
    check(tag, 64'(log_q.size()), 64'(n));
  endtask
  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask
  initial begin
    drive();
    tick();
    tick();
    check("rst_in_tready", 64'(in_tready), 64'h0);
    check("rst_out", 64'({out_tvalid, out_tdata, out_tdest, out_tuser, out_tlast, out_src_id}), 64'h0);
    check("rst_status", 64'({pkt_cnt, hdr_err, hdr_err_src, busy}), 64'h0);
    rst = 1'b0;
    for (int p = 0; p < 2; p++) for (int s = 0; s < NS; s++) push_pkt(s, p, 3, 1'b1);
    drive();
    wait_log(24, 100, "t1_len");
    for (int k = 0; k < 24; k++) check($sformatf("t1_beat%0d", k), 64'(log_q[k]), 64'(exp_obs((k / 3) % 4, k / 12, k % 3, 3, 1'b1)));
    check("t1_no_bubble", 64'(log_cyc[23] - log_cyc[0]), 64'd23);
    check("t1_cnt", 64'(pkt_cnt), 64'h02020202);
    clear_log();
    push_pkt(0, 8'h10, 1, 1'b1);
    drive();
    wait_log(1, 20, "t2_pre_len");
    push_pkt(1, 8'h20, 5, 1'b1);
    push_pkt(0, 8'h21, 2, 1'b1);
    push_pkt(2, 8'h22, 2, 1'b1);
    drive();
    wait_log(10, 50, "t2_len");
    for (int b = 0; b < 5; b++) check($sformatf("t2_src1_b%0d", b), 64'(log_q[1+b]), 64'(exp_obs(1, 8'h20, b, 5, 1'b1)));
    check("t2_contig", 64'(log_cyc[5] - log_cyc[1]), 64'd4);
    check("t2_next_src2", 64'(log_q[6]), 64'(exp_obs(2, 8'h22, 0, 2, 1'b1)));
    check("t2_then_src0", 64'(log_q[8]), 64'(exp_obs(0, 8'h21, 0, 2, 1'b1)));
    clear_log();
    unstable = 0;
    push_pkt(1, 8'h30, 4, 1'b1);
    drive();
    tick();
    tick();
    out_tready = 1'b0;
    tick();
    tick();
    check("t3_stall_hold", 64'({out_tvalid, out_tdata}), 64'({1'b1, mkd(1, 8'h30, 1)}));
    out_tready = 1'b1;
    wait_log(4, 30, "t3_len");
    for (int b = 0; b < 4; b++) check($sformatf("t3_b%0d", b), 64'(log_q[b]), 64'(exp_obs(1, 8'h30, b, 4, 1'b1)));
    check("t3_stable", 64'(unstable), 64'd0);
    check("t3_cnt1", 64'(cnt(1)), 64'd4);
    clear_log();
    busy_seen = 0;
    push_pkt(3, 8'h40, 1, 1'b1);
    push_pkt(3, 8'h41, 1, 1'b1);
    push_pkt(0, 8'h42, 1, 1'b1);
    drive();
    wait_log(3, 20, "t4_len");
    check("t4_g0", 64'(log_q[0]), 64'(exp_obs(3, 8'h40, 0, 1, 1'b1)));
    check("t4_g1", 64'(log_q[1]), 64'(exp_obs(0, 8'h42, 0, 1, 1'b1)));
    check("t4_g2", 64'(log_q[2]), 64'(exp_obs(3, 8'h41, 0, 1, 1'b1)));
    check("t4_never_busy", 64'(busy_seen), 64'd0);
    clear_log();
    check("t5_err_clear", 64'(hdr_err), 64'd0);
    push_pkt(2, 8'h50, 2, 1'b0);
    drive();
    wait_log(2, 20, "t5_len");
    check("t5_fwd", 64'(log_q[0]), 64'(exp_obs(2, 8'h50, 0, 2, 1'b0)));
    check("t5_err", 64'({hdr_err, hdr_err_src}), 64'({1'b1, 2'd2}));
    push_pkt(1, 8'h51, 2, 1'b0);
    drive();
    wait_log(4, 20, "t5_len2");
    check("t5_err_sticky", 64'({hdr_err, hdr_err_src}), 64'({1'b1, 2'd2}));
    clear_log();
    push_pkt(1, 8'h60, 4, 1'b1);
    drive();
    tick();
    tick();
    check("t6_locked", 64'(busy), 64'd1);
    rst = 1'b1;
    q[1].delete();
    drive();
    tick();
    check("t6_rst_out", 64'({out_tvalid, busy, hdr_err}), 64'h0);
    check("t6_rst_cnt", 64'(pkt_cnt), 64'h0);
    rst = 1'b0;
    clear_log();
    push_pkt(3, 8'h61, 1, 1'b1);
    push_pkt(2, 8'h62, 1, 1'b1);
    drive();
    wait_log(2, 20, "t6_len");
    check("t6_first_low", 64'(log_q[0]), 64'(exp_obs(2, 8'h62, 0, 1, 1'b1)));
    check("t6_second", 64'(log_q[1]), 64'(exp_obs(3, 8'h61, 0, 1, 1'b1)));
    clear_log();
    for (int k = 0; k < 255; k++) push_pkt(0, k, 1, 1'b1);
    drive();
    wait_log(255, 600, "wrap_len");
    check("wrap_max", 64'(cnt(0)), 64'hFF);
    push_pkt(0, 8'hEE, 1, 1'b1);
    drive();
    wait_log(256, 20, "wrap_len2");
    check("wrap_zero", 64'(cnt(0)), 64'h0);
    check("tready_onehot0", 64'(bad_oh), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
